// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Function : Instruction fetch unit. Owns the PC, fetches from a combinational
//            instruction memory, and buffers words in a 2-entry FIFO for decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_im_addr,
    input  logic [31:0] i_im_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_align_err
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic        r_align_err;
    logic [31:0] r_buf_instr [DEPTH];
    logic [31:0] r_buf_pc    [DEPTH];

    logic        w_fire;
    logic        w_fetch;

    assign w_fire  = o_out_valid & i_out_ready;
    // A full buffer can still accept a word when its head leaves this cycle.
    assign w_fetch = ~i_redirect_valid & ((r_count != c_FULL) | w_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_count     <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_align_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= 32'h0;
                r_buf_pc[i]    <= 32'h0;
            end
        end else if (i_redirect_valid) begin
            r_pc     <= {i_redirect_pc[31:2], 2'b00};
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            if (i_redirect_pc[1:0] != 2'b00) begin
                r_align_err <= 1'b1;
            end
        end else begin
            if (w_fetch) begin
                r_buf_instr[r_wr_ptr] <= i_im_data;
                r_buf_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr              <= ~r_wr_ptr;
                r_pc                  <= r_pc + 32'd4;
            end
            if (w_fire) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_fetch, w_fire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_im_addr   = r_pc;
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_instr = r_buf_instr[r_rd_ptr];
    assign o_out_pc    = r_buf_pc[r_rd_ptr];
    assign o_align_err = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Function : Scoreboard bench for if_fetch with a combinational memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] w_im_addr;
    logic [31:0] w_im_data;
    logic        w_out_valid;
    logic        r_out_ready = 1'b0;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        r_redirect_valid = 1'b0;
    logic [31:0] r_redirect_pc = 32'h0;
    logic        w_align_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_beats = 0;
    logic [31:0] q_exp_pc [$];
    logic [31:0] r_mon_exp;

    if_fetch #(.RESET_PC(c_RESET_PC), .DEPTH(2)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_im_addr        (w_im_addr),
        .i_im_data        (w_im_data),
        .o_out_valid      (w_out_valid),
        .i_out_ready      (r_out_ready),
        .o_out_instr      (w_out_instr),
        .o_out_pc         (w_out_pc),
        .i_redirect_valid (r_redirect_valid),
        .i_redirect_pc    (r_redirect_pc),
        .o_align_err      (w_align_err)
    );

    always #5 clk = ~clk;

    // Memory word k holds A000_0000 + k.
    assign w_im_data = 32'hA000_0000 + {2'b00, w_im_addr[31:2]};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_seed(input logic [31:0] start);
        q_exp_pc.delete();
        for (int k = 0; k < 64; k++) begin
            q_exp_pc.push_back(start + 32'(4 * k));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every handshake that will complete at the coming edge is scored here.
    always @(negedge clk) begin
        if (rst_n && w_out_valid && r_out_ready && !r_redirect_valid) begin
            if (q_exp_pc.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                r_mon_exp = q_exp_pc.pop_front();
                check("out_pc", w_out_pc, r_mon_exp);
                check("out_instr", w_out_instr, 32'hA000_0000 + (r_mon_exp >> 2));
                n_beats++;
            end
        end
    end

    initial begin
        #12;
        check("rst_valid", {31'h0, w_out_valid}, 32'd0);
        check("rst_pc", w_out_pc, 32'h0);
        check("rst_instr", w_out_instr, 32'h0);
        check("rst_align", {31'h0, w_align_err}, 32'd0);
        check("rst_im_addr", w_im_addr, c_RESET_PC);

        // Release with decode stalled: buffer fills and PC stops at 8.
        @(negedge clk);
        rst_n = 1'b1;
        sb_seed(c_RESET_PC);
        #1;
        check("valid_pre_edge", {31'h0, w_out_valid}, 32'd0);
        tick();
        check("valid_first_edge", {31'h0, w_out_valid}, 32'd1);
        check("first_pc", w_out_pc, c_RESET_PC);
        repeat (4) tick();
        check("sat_valid", {31'h0, w_out_valid}, 32'd1);
        check("sat_pc", w_out_pc, 32'h0);
        check("sat_im_addr", w_im_addr, 32'h8);

        r_out_ready = 1'b1;
        repeat (10) tick();
        check("stream_beats", 32'(n_beats), 32'd10);

        // Redirect while full with decode ready.
        r_out_ready = 1'b0;
        repeat (3) tick();
        r_out_ready      = 1'b1;
        r_redirect_valid = 1'b1;
        r_redirect_pc    = 32'h40;
        sb_seed(32'h40);
        tick();
        r_redirect_valid = 1'b0;
        check("redir_flush_valid", {31'h0, w_out_valid}, 32'd0);
        tick();
        check("redir_valid", {31'h0, w_out_valid}, 32'd1);
        check("redir_pc", w_out_pc, 32'h40);
        check("redir_instr", w_out_instr, 32'hA000_0010);
        repeat (5) tick();

        // Misaligned redirect.
        r_redirect_valid = 1'b1;
        r_redirect_pc    = 32'h42;
        sb_seed(32'h40);
        tick();
        r_redirect_valid = 1'b0;
        check("align_set", {31'h0, w_align_err}, 32'd1);
        tick();
        check("align_pc", w_out_pc, 32'h40);
        repeat (20) tick();
        check("align_sticky", {31'h0, w_align_err}, 32'd1);

        // Back-to-back redirects.
        r_redirect_valid = 1'b1;
        r_redirect_pc    = 32'h10;
        sb_seed(32'h10);
        tick();
        check("b2b_valid0", {31'h0, w_out_valid}, 32'd0);
        r_redirect_pc = 32'h80;
        sb_seed(32'h80);
        tick();
        check("b2b_valid1", {31'h0, w_out_valid}, 32'd0);
        r_redirect_valid = 1'b0;
        tick();
        check("b2b_pc", w_out_pc, 32'h80);
        repeat (5) tick();

        // Address wrap past FFFF_FFFC.
        r_redirect_valid = 1'b1;
        r_redirect_pc    = 32'hFFFF_FFF8;
        sb_seed(32'hFFFF_FFF8);
        tick();
        r_redirect_valid = 1'b0;
        repeat (6) tick();
        check("wrap_im_addr_lo", {28'h0, w_im_addr[31:28]}, 32'h0);

        // Asynchronous reset in the middle of a cycle with a full buffer.
        r_out_ready = 1'b0;
        repeat (3) tick();
        check("pre_areset_valid", {31'h0, w_out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'h0, w_out_valid}, 32'd0);
        check("areset_align", {31'h0, w_align_err}, 32'd0);
        check("areset_im_addr", w_im_addr, c_RESET_PC);
        sb_seed(c_RESET_PC);
        r_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_areset_pc", w_out_pc, c_RESET_PC);
        repeat (5) tick();
        check("beats_total_min", {31'h0, (n_beats >= 40)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch unit: the requester side of the instruction memory interface.
- Owns the program counter and drives a 32-bit byte address to instruction memory, which returns the 32-bit word combinationally in the same cycle.
- Buffers fetched words with their PCs in a 2-entry FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
DEPTH, 2, fetch buffer entries (fixed at 2; any other value is unsupported)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
im_addr  output  32  byte address to instruction memory (= pc)
im_data  input  32  instruction word at im_addr, valid same cycle
out_valid  output  1  out_instr/out_pc hold a valid entry
out_ready  input  1  decode accepts head entry this cycle
out_instr  output  32  head-of-buffer instruction
out_pc  output  32  byte address of out_instr
redirect_valid  input  1  replace pc and flush buffer
redirect_pc  input  32  new fetch byte address
align_err  output  1  sticky: a redirect had redirect_pc[1:0] != 0

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_PC; buffer empty (count=0, rd/wr pointers 0); align_err = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0.
- im_addr = pc (continuous). No request or strobe toward memory: memory is combinational.
- fire_out = out_valid & out_ready.
- fetch = !redirect_valid & (count < 2 | fire_out): write {im_data, pc} at wr_ptr and advance pc to pc+4 (mod 2^32, natural wrap).
- Buffer:
  - count in 0..2; out_valid = (count != 0).
  - out_instr/out_pc come from the entry at rd_ptr and are registered storage (no combinational path from im_data).
  - Simultaneous fetch and fire_out with count=2 is legal; count stays 2.
  - Full (count=2) and no fire_out: pc holds and no write occurs.
  - Empty: out_valid=0; out_ready is ignored.
- Latency:
  - First rising edge after rst_n deassert writes RESET_PC's word; out_valid=1 from that edge.
  - Steady state with out_ready held high: one instruction per cycle, PCs consecutive.
- Redirect (redirect_valid=1 at edge N), highest priority:
  - Buffer flushed (count=0, pointers 0).
  - pc = {redirect_pc[31:2], 2'b00}.
  - No fetch write at edge N; any fire_out at edge N is discarded; out_valid=0 after edge N.
  - Edge N+1 writes the word at the new pc; out_valid=1 after edge N+1 unless redirect repeats.
  - If redirect_pc[1:0] != 0, align_err sets at edge N and stays set until reset.
  - Back-to-back redirects: only the last one takes effect; out_valid stays 0 throughout.
- out_instr/out_pc when out_valid=0: hold last content; decode must not sample them.
- Reset mid-stream: all buffered entries are lost; fetch resumes at RESET_PC.
- Address width: pc is a full 32-bit value; memory uses only its word index bits. Wrap past 32'hFFFF_FFFC goes to 0.

Test Plan:
- Reset release, out_ready=1, memory word k = 32'hA000_0000+k -> out_pc 0,4,8,… on consecutive cycles; out_instr A0000000, A0000001, …; first valid one edge after reset.
- out_ready=0 for 5 cycles after reset -> count saturates at 2; pc holds 8; out_pc=0 stable; raise out_ready -> 0,4,8,… with no gap or duplicate.
- Redirect to 32'h40 while buffer full and out_ready=1 -> next edge out_valid=0; following edge out_pc=32'h40 with mem[16]; no stale entry (0/4) ever appears.
- Redirect to 32'h42 -> fetch at 32'h40; align_err=1 and remains 1 over 20 cycles until rst_n pulses low.
- Redirect on consecutive cycles (pc 32'h10 then 32'h80) -> out_valid stays 0 through both; first delivered out_pc=32'h80.
- Assert rst_n low asynchronously mid-cycle with count=2 -> out_valid drops immediately; after release, out_pc=RESET_PC first.
